// File: rtl/oq_fifo_axis_reader.sv
// Output-queue FIFO reader: pops a standard-read FIFO into a credit-managed buffer and drives AXI4-Stream.
// Optional macro OQ_READER_DROP_ERR_EN discards packets whose first entry carries err=1.
module oq_fifo_axis_reader #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int BUF_DEPTH            = 4,
    localparam int KEEP_W  = C_M_AXIS_DATA_WIDTH / 8,
    localparam int ENTRY_W = C_M_AXIS_DATA_WIDTH + KEEP_W + C_M_AXIS_TUSER_WIDTH + 2
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [ENTRY_W-1:0]              fifo_dout,
    input  logic                            fifo_valid,
    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0]               m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [31:0]                     pkt_count,
    output logic [31:0]                     drop_count
);
    localparam int IDX_W    = $clog2(BUF_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int PAY_W    = ENTRY_W - 1;
    localparam int KEEP_LO  = C_M_AXIS_DATA_WIDTH;
    localparam int USER_LO  = KEEP_LO + KEEP_W;
    localparam int LAST_BIT = USER_LO + C_M_AXIS_TUSER_WIDTH;
    localparam int ERR_BIT  = LAST_BIT + 1;

`ifdef OQ_READER_DROP_ERR_EN
    typedef enum logic [1:0] {ST_SOP, ST_MOP, ST_DROP} state_t;
`else
    typedef enum logic [1:0] {ST_SOP, ST_MOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      pkt_count_q, pkt_count_d;
    logic [PAY_W-1:0] mem_q [BUF_DEPTH];
    logic [PAY_W-1:0] mem_d [BUF_DEPTH];

    logic [PTR_W-1:0] occupancy;
    logic [PAY_W-1:0] head;
    logic             accept;
    logic             push;
    logic             pop;
    logic             entry_last;

    assign occupancy = wr_ptr_q - rd_ptr_q;

    // Credit: an outstanding read always has a guaranteed slot when its data returns.
    assign fifo_rd_en = !fifo_empty &&
                        (({1'b0, occupancy} + {{PTR_W{1'b0}}, inflight_q}) < (PTR_W+1)'(BUF_DEPTH));

    assign head          = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign m_axis_tvalid = (occupancy != '0);
    assign m_axis_tdata  = head[C_M_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = head[USER_LO-1:KEEP_LO];
    assign m_axis_tuser  = head[LAST_BIT-1:USER_LO];
    assign m_axis_tlast  = head[LAST_BIT];
    assign pkt_count     = pkt_count_q;

    assign accept     = fifo_valid && inflight_q;
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign entry_last = fifo_dout[LAST_BIT];

`ifdef OQ_READER_DROP_ERR_EN
    logic [31:0] drop_count_q, drop_count_d;
    logic        entry_err;
    logic        drop_inc;

    assign entry_err  = fifo_dout[ERR_BIT];
    assign drop_count = drop_count_q;
`else
    logic unused_err;

    assign unused_err = fifo_dout[ERR_BIT];
    assign drop_count = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
`ifdef OQ_READER_DROP_ERR_EN
        drop_inc = 1'b0;
`endif
        if (accept) begin
            case (state_q)
                ST_SOP: begin
                    push = 1'b1;
                    if (!entry_last) state_d = ST_MOP;
`ifdef OQ_READER_DROP_ERR_EN
                    if (entry_err) begin
                        push     = 1'b0;
                        state_d  = entry_last ? ST_SOP : ST_DROP;
                        drop_inc = entry_last;
                    end
`endif
                end
                ST_MOP: begin
                    push = 1'b1;
                    if (entry_last) state_d = ST_SOP;
                end
`ifdef OQ_READER_DROP_ERR_EN
                ST_DROP: begin
                    if (entry_last) begin
                        state_d  = ST_SOP;
                        drop_inc = 1'b1;
                    end
                end
`endif
                default: state_d = ST_SOP;
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[IDX_W-1:0]] = fifo_dout[PAY_W-1:0];
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        pkt_count_d = pkt_count_q + 32'(pop && m_axis_tlast);
        if (fifo_rd_en)      inflight_d = 1'b1;
        else if (fifo_valid) inflight_d = 1'b0;
        else                 inflight_d = inflight_q;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= ST_SOP;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            pkt_count_q <= '0;
            // NOTE: the buffer is reset because its head drives m_axis_* directly and must read 0.
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            pkt_count_q <= pkt_count_d;
            mem_q       <= mem_d;
        end
    end

`ifdef OQ_READER_DROP_ERR_EN
    assign drop_count_d = drop_count_q + 32'(drop_inc);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) drop_count_q <= '0;
        else             drop_count_q <= drop_count_d;
    end
`endif

endmodule

// File: tb/tb_oq_fifo_axis_reader.sv
// Self-checking bench for oq_fifo_axis_reader: directed table, latency/backpressure/reset
// sequences and a randomized packet-level scoreboard.
`timescale 1ns/1ps
module tb_oq_fifo_axis_reader;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 128;
    localparam int EW = DW + KW + UW + 2;
`ifdef OQ_READER_DROP_ERR_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] tdata;
        logic [KW-1:0] tkeep;
        logic [UW-1:0] tuser;
        logic          tlast;
    } beat_t;

    typedef struct {
        int beats;
        int err_beat;
        int exp_beats;
        int exp_pkts;
        int exp_drops;
    } vec_t;

    logic          axi_aclk;
    logic          axi_resetn;
    logic [EW-1:0] fifo_dout;
    logic          fifo_valid;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   pkt_count;
    logic [31:0]   drop_count;

    oq_fifo_axis_reader dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .fifo_dout     (fifo_dout),
        .fifo_valid    (fifo_valid),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [EW-1:0] fifo_q  [$];
    logic [EW-1:0] stage_q [$];
    beat_t         exp_q   [$];
    int            exp_pkts  = 0;
    int            exp_drops = 0;
    int            beats_rx  = 0;
    int            rd_cnt    = 0;
    bit            push_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Upstream standard-read FIFO: data and valid appear the cycle after rd_en.
    logic prev_rd_en;
    always @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            fifo_q.delete();
            fifo_valid <= 1'b0;
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
            prev_rd_en <= 1'b0;
        end else begin
            assert (!fifo_valid || prev_rd_en) else $error("fifo_valid without outstanding request");
            prev_rd_en <= fifo_rd_en;
            if (fifo_rd_en && fifo_q.size() > 0) begin
                fifo_dout  <= fifo_q.pop_front();
                fifo_valid <= 1'b1;
            end else begin
                fifo_valid <= 1'b0;
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Stream monitor: in-order scoreboard plus AXIS stability while stalled.
    bit    stall_q = 1'b0;
    beat_t stall_beat;
    beat_t got;
    beat_t e;
    always @(negedge axi_aclk) begin
        if (!axi_resetn) begin
            stall_q = 1'b0;
        end else begin
            got = '{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (stall_q) begin
                check("stall tvalid held", m_axis_tvalid, 1);
                check("stall beat stable", got, stall_beat);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats_rx++;
                if (exp_q.size() == 0) begin
                    check("unexpected beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat tdata", got.tdata, e.tdata);
                    check("beat tkeep", got.tkeep, e.tkeep);
                    check("beat tuser", got.tuser, e.tuser);
                    check("beat tlast", got.tlast, e.tlast);
                end
            end
            stall_q    = m_axis_tvalid && !m_axis_tready;
            stall_beat = got;
        end
    end

    always @(negedge axi_aclk) if (axi_resetn && fifo_rd_en) rd_cnt++;

    // Reference model: a packet is discarded exactly when the drop feature is on and its first beat has err.
    task automatic make_pkt(input int beats, input int err_beat);
        bit    dropped;
        beat_t b;
        dropped = DROP_EN && (err_beat == 0);
        for (int i = 0; i < beats; i++) begin
            b.tdata = {$urandom, $urandom};
            b.tkeep = 8'($urandom);
            b.tuser = {$urandom, $urandom, $urandom, $urandom};
            b.tlast = (i == beats - 1);
            stage_q.push_back({(i == err_beat), b.tlast, b.tuser, b.tkeep, b.tdata});
            if (!dropped) exp_q.push_back(b);
        end
        if (dropped) exp_drops++;
        else         exp_pkts++;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n && stage_q.size() > 0; i++) fifo_q.push_back(stage_q.pop_front());
    endtask

    task automatic wait_drain(input string name);
        int idle = 0;
        int cyc  = 0;
        while (idle < 3 && cyc < 3000) begin
            @(negedge axi_aclk);
            cyc++;
            if (fifo_q.size() == 0 && !fifo_valid && !m_axis_tvalid) idle++;
            else idle = 0;
        end
        check($sformatf("%s drained", name), idle >= 3, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vecs [6];
    int          b0;
    int          r0;
    logic [31:0] pk0;
    logic [31:0] dr0;
    logic [DW-1:0] head0;
    bit          found;

    initial begin
        vecs[0] = '{2, -1, 2, 1, 0};
        vecs[1] = '{3,  0, DROP_EN ? 0 : 3, DROP_EN ? 0 : 1, DROP_EN ? 1 : 0};
        vecs[2] = '{1, -1, 1, 1, 0};
        vecs[3] = '{1,  0, DROP_EN ? 0 : 1, DROP_EN ? 0 : 1, DROP_EN ? 1 : 0};
        vecs[4] = '{4,  2, 4, 1, 0};
        vecs[5] = '{3, -1, 3, 1, 0};

        axi_resetn    = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge axi_aclk);
        check("reset rd_en", fifo_rd_en, 0);
        check("reset tvalid", m_axis_tvalid, 0);
        check("reset tdata", m_axis_tdata, 0);
        check("reset tkeep", m_axis_tkeep, 0);
        check("reset tuser", m_axis_tuser, 0);
        check("reset tlast", m_axis_tlast, 0);
        check("reset pkt_count", pkt_count, 0);
        check("reset drop_count", drop_count, 0);
        axi_resetn = 1'b1;
        @(negedge axi_aclk);
        check("post-reset idle tvalid", m_axis_tvalid, 0);

        // Latency: rd_en N, fifo_valid N+1, tvalid N+2, then three back-to-back beats.
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b1;
        make_pkt(3, -1);
        push_n(3);
        @(negedge axi_aclk); check("lat rd_en before empty drops", fifo_rd_en, 0);
        @(negedge axi_aclk); check("lat rd_en cycle N", fifo_rd_en, 1);
        @(negedge axi_aclk); check("lat fifo_valid N+1", fifo_valid, 1);
                             check("lat tvalid N+1", m_axis_tvalid, 0);
        @(negedge axi_aclk); check("lat tvalid N+2", m_axis_tvalid, 1);
                             check("lat beat0 tlast", m_axis_tlast, 0);
        @(negedge axi_aclk); check("lat beat1 tvalid", m_axis_tvalid, 1);
                             check("lat beat1 tlast", m_axis_tlast, 0);
        @(negedge axi_aclk); check("lat beat2 tvalid", m_axis_tvalid, 1);
                             check("lat beat2 tlast", m_axis_tlast, 1);
        @(negedge axi_aclk); check("lat tvalid after packet", m_axis_tvalid, 0);
                             check("lat pkt_count", pkt_count, 1);

        // Directed packet table, full-rate drain.
        foreach (vecs[k]) begin
            b0  = beats_rx;
            pk0 = pkt_count;
            dr0 = drop_count;
            make_pkt(vecs[k].beats, vecs[k].err_beat);
            push_n(vecs[k].beats);
            wait_drain($sformatf("vec%0d", k));
            check($sformatf("vec%0d beats", k), beats_rx - b0, vecs[k].exp_beats);
            check($sformatf("vec%0d pkts", k), pkt_count - pk0, vecs[k].exp_pkts);
            check($sformatf("vec%0d drops", k), drop_count - dr0, vecs[k].exp_drops);
        end

        // Backpressure: 20 entries with tready low -> only the credit window is popped.
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b0;
        b0  = beats_rx;
        r0  = rd_cnt;
        pk0 = pkt_count;
        for (int p = 0; p < 4; p++) make_pkt(5, -1);
        head0 = exp_q[0].tdata;
        push_n(20);
        repeat (30) @(negedge axi_aclk);
        check("bp pop count", rd_cnt - r0, 4);
        check("bp rd_en idle", fifo_rd_en, 0);
        check("bp tvalid", m_axis_tvalid, 1);
        check("bp head tdata", m_axis_tdata, head0);
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b1;
        wait_drain("bp");
        check("bp beats", beats_rx - b0, 20);
        check("bp pkts", pkt_count - pk0, 4);

        // FIFO empties mid-packet for several cycles.
        b0  = beats_rx;
        pk0 = pkt_count;
        make_pkt(6, -1);
        push_n(3);
        repeat (8) @(negedge axi_aclk);
        check("gap tvalid low", m_axis_tvalid, 0);
        check("gap beats before low", beats_rx - b0, 3);
        check("gap no pkt yet", pkt_count - pk0, 0);
        push_n(3);
        wait_drain("gap");
        check("gap beats", beats_rx - b0, 6);
        check("gap pkts", pkt_count - pk0, 1);

        // Randomized traffic with 50% tready.
        push_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    int nb;
                    int eb;
                    int r;
                    nb = $urandom_range(1, 4);
                    r  = $urandom_range(0, 3);
                    eb = (r == 0) ? 0 : ((r == 1) ? int'($urandom_range(0, nb - 1)) : -1);
                    make_pkt(nb, eb);
                    while (stage_q.size() != 0) begin
                        repeat ($urandom_range(0, 1)) @(posedge axi_aclk);
                        @(posedge axi_aclk); #1;
                        fifo_q.push_back(stage_q.pop_front());
                    end
                end
                push_done = 1'b1;
            end
            begin
                while (!push_done) begin
                    @(posedge axi_aclk); #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b1;
        wait_drain("rand");
        check("rand pkt_count", pkt_count, exp_pkts);
        check("rand drop_count", drop_count, exp_drops);
        check("rand scoreboard empty", exp_q.size(), 0);

        // Reset mid-packet while a beat is presented.
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b0;
        make_pkt(6, -1);
        push_n(6);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge axi_aclk);
            if (m_axis_tvalid) found = 1'b1;
        end
        check("rst tvalid before reset", found, 1);
        #2 axi_resetn = 1'b0;
        #1;
        check("rst tvalid", m_axis_tvalid, 0);
        check("rst rd_en", fifo_rd_en, 0);
        check("rst tdata", m_axis_tdata, 0);
        check("rst pkt_count", pkt_count, 0);
        check("rst drop_count", drop_count, 0);
        exp_q.delete();
        stage_q.delete();
        exp_pkts  = 0;
        exp_drops = 0;
        repeat (2) @(negedge axi_aclk);
        axi_resetn = 1'b1;
        @(posedge axi_aclk); #1;
        m_axis_tready = 1'b1;
        b0 = beats_rx;
        make_pkt(2, -1);
        push_n(2);
        wait_drain("post-rst");
        check("post-rst beats", beats_rx - b0, 2);
        check("post-rst pkt_count", pkt_count, 1);
        check("post-rst drop_count", drop_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
